// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared types and constants for the data-memory arbiter.
//            - state_t      : arbiter FSM states (IDLE, ISSUE, RESP)
//            - REQ_CPU/AUX  : requester index constants (0 = CPU, 1 = aux)
//            - DEF_ADDR_W   : default word-address width
//            - DEF_DATA_W   : default data width
// Config   : DMEM_ARB_RR_EN (see arb_pick) selects round-robin tie-break
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_AUX = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick
// Purpose  : Combinational winner select for the two-requester arbiter.
// Ports    : i_req[1:0] - pending requests (bit n = requester n)
//            i_last     - index of the most recently served requester
//            o_winner   - index of the selected requester (valid if |i_req)
// Config   : DMEM_ARB_RR_EN defined   -> tie goes to the requester that was
//                                        not served last (round-robin)
//            DMEM_ARB_RR_EN undefined -> tie goes to requester 0
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_winner
);

`ifndef DMEM_ARB_RR_EN
  // Fixed priority never looks at the history pointer.
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  always_comb begin
    o_winner = REQ_CPU;
    if (i_req == 2'b10) begin
      o_winner = REQ_AUX;
    end else if (i_req == 2'b11) begin
`ifdef DMEM_ARB_RR_EN
      o_winner = ~i_last;
`else
      o_winner = REQ_CPU;
`endif
    end
  end

endmodule : arb_pick
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares a single-port synchronous data memory between the CPU
//            load/store port (requester 0) and an auxiliary master
//            (requester 1). Level request / one-cycle acknowledge handshake;
//            every transaction takes IDLE -> ISSUE -> RESP (3 cycles).
// Ports    : clk, rst_n              - clock, async active-low reset
//            i_req*/i_we*/i_addr*/i_wdata* - requester command inputs
//            o_ack*, o_rdata*        - completion pulse and read data
//            o_mem_address/o_mem_write/o_mem_writedata - memory command
//            i_mem_readdata          - memory read data (1-cycle latency)
//            o_busy                  - high while in ISSUE or RESP
// Config   : DMEM_ARB_RR_EN - round-robin tie-break (default: fixed prio)
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_we0,
  input  logic              i_we1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_ack0,
  output logic              o_ack1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_write,
  output logic [DATA_W-1:0] o_mem_writedata,
  input  logic [DATA_W-1:0] i_mem_readdata,
  output logic              o_busy
);

  state_t            r_state;
  logic              r_gnt;
  logic              r_last;
  logic              r_we;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic              w_win;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_resp_rd;

  arb_pick u_pick (
    .i_req    ({i_req1, i_req0}),
    .i_last   (r_last),
    .o_winner (w_win)
  );

  assign w_sel_we    = w_win ? i_we1    : i_we0;
  assign w_sel_addr  = w_win ? i_addr1  : i_addr0;
  assign w_sel_wdata = w_win ? i_wdata1 : i_wdata0;

  // The RAM only presents data during RESP, which is also the ack cycle, so
  // the granted port sees the RAM output directly in that cycle and the
  // captured copy afterwards.
  assign w_resp_rd = (r_state == RESP) && !r_we;
  assign o_rdata0  = (w_resp_rd && (r_gnt == REQ_CPU)) ? i_mem_readdata : r_rdata0;
  assign o_rdata1  = (w_resp_rd && (r_gnt == REQ_AUX)) ? i_mem_readdata : r_rdata1;

  // The memory command registers double as the latched addr/wdata of the
  // granted request: they are loaded when leaving IDLE so the command is on
  // the bus for the whole ISSUE cycle and simply holds afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_gnt           <= REQ_CPU;
      r_last          <= REQ_AUX;
      r_we            <= 1'b0;
      r_rdata0        <= '0;
      r_rdata1        <= '0;
      o_ack0          <= 1'b0;
      o_ack1          <= 1'b0;
      o_mem_address   <= '0;
      o_mem_write     <= 1'b0;
      o_mem_writedata <= '0;
      o_busy          <= 1'b0;
    end else begin
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_mem_write <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req0 || i_req1) begin
            r_gnt           <= w_win;
            r_we            <= w_sel_we;
            o_mem_address   <= w_sel_addr;
            o_mem_writedata <= w_sel_wdata;
            o_mem_write     <= w_sel_we;
            o_busy          <= 1'b1;
            r_state         <= ISSUE;
          end
        end
        ISSUE: begin
          // Completion does not depend on req still being high.
          o_ack0  <= (r_gnt == REQ_CPU);
          o_ack1  <= (r_gnt == REQ_AUX);
          r_state <= RESP;
        end
        RESP: begin
          if (!r_we) begin
            if (r_gnt == REQ_CPU) begin
              r_rdata0 <= i_mem_readdata;
            end else begin
              r_rdata1 <= i_mem_readdata;
            end
          end
          r_last  <= r_gnt;
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          o_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : dmem_arbiter
`default_nettype wire
